prog_loader: RTL

//  Writer side of the picoMIPS program-memory interface. Receives a program image as a byte stream
//  (valid/ready, e.g. from a UART receiver) and packs it into Isize-bit instruction words.

---
 rtl/prog_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: writer side of the picoMIPS program-memory interface.
// Receives a byte-stream program image (COUNT, N x 3-byte words MS-first, CSUM),
// packs each word into an Isize-bit instruction, writes it into a 2^Psize-word
// instruction RAM, and releases the processor only after a fully loaded image
// whose XOR checksum matches.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   load_start   in   single-cycle pulse: begin receiving a new image
//   rx_data      in   stream byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (decoded from state)
//   address      in   processor instruction fetch address
//   I            out  instruction at address (combinational RAM read)
//   cpu_hold     out  1 = processor held in reset / PC frozen
//   load_done    out  1 = last image loaded with a good checksum
//   load_err     out  1 = last image aborted (bad count or bad checksum)
//   words_loaded out  words written in the current or last load
module prog_loader #(
  parameter int unsigned Psize = 4,
  parameter int unsigned Isize = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [Psize-1:0] address,
  output logic [Isize-1:0] I,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [Psize:0]   words_loaded
);

  localparam int unsigned NB    = 3;
  localparam int unsigned DEPTH = 1 << Psize;
  localparam int unsigned CW    = Psize + 1;
  localparam int unsigned PW    = 8 * (NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      xor_q, xor_d;
  logic [PW-1:0]   bytes_q, bytes_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   wl_q, wl_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            xfer_c;
  logic            we_c;
  logic [Isize-1:0] wdata_c;
  logic [CW-1:0]   wl_inc_c;

  logic [Isize-1:0] mem [DEPTH];

  // Handshake is open only while the image is being received.
  always_comb begin
    rx_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CSUM);
  end

  assign xfer_c   = rx_valid & rx_ready;
  assign wl_inc_c = wl_q + CW'(1);
  // Upper bits of the 24-bit word beyond Isize are dropped here (they still feed the XOR).
  assign wdata_c  = Isize'({bytes_q, rx_data});

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    xor_d   = xor_q;
    bytes_d = bytes_q;
    idx_d   = idx_q;
    n_d     = n_q;
    wl_d    = wl_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    we_c    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_start) begin
          state_d = S_COUNT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          xor_d   = '0;
          idx_d   = '0;
          hold_d  = 1'b1;
        end
      end

      S_COUNT: begin
        if (xfer_c) begin
          xor_d = rx_data;
          // Counts that cannot fit the RAM are rejected before anything is written.
          if ((rx_data == 8'd0) || (32'(rx_data) > DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            n_d     = CW'(rx_data);
            idx_d   = '0;
          end
        end
      end

      S_DATA: begin
        if (xfer_c) begin
          xor_d = xor_q ^ rx_data;
          if (idx_q == 2'(NB - 1)) begin
            we_c  = 1'b1;
            wl_d  = wl_inc_c;
            idx_d = '0;
            if (wl_inc_c == n_q) begin
              state_d = S_CSUM;
            end
          end else begin
            bytes_d = {bytes_q[PW-9:0], rx_data};
            idx_d   = idx_q + 2'd1;
          end
        end
      end

      S_CSUM: begin
        if (xfer_c) begin
          if (rx_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      xor_q   <= '0;
      bytes_q <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      wl_q    <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xor_q   <= xor_d;
      bytes_q <= bytes_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Instruction RAM: contents survive reset; a partial image is never released.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[wl_q[Psize-1:0]] <= wdata_c;
    end
  end

  assign I            = mem[address];
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;

endmodule
